// File: rtl/neural_pkg.sv
// Shared definitions for the neural processor datapath: operand width, word type, opcodes.
package neural_pkg;

  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] word_t;

  localparam logic [1:0] INSTR_I = 2'b00;
  localparam logic [1:0] INSTR_M = 2'b01;
  localparam logic [1:0] INSTR_A = 2'b10;
  localparam logic [1:0] INSTR_F = 2'b11;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset; the owner tracks which entries are valid.
module fifo_mem #(
  parameter int DATA_W = neural_pkg::DATA_W,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/input_fifo.sv
// First-word-fall-through operand FIFO for the MAC path; flags derive from registered pointers only.
// Optional sticky overflow/underflow flags are built when INPUT_FIFO_ERR_EN is defined.
module input_fifo #(
  parameter int DATA_W       = neural_pkg::DATA_W,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 14,
  localparam int ADDR_W      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              input_en,
  input  logic [DATA_W-1:0] input_d,
  input  logic              input_de,
  output logic [DATA_W-1:0] input_q,
  output logic              input_fifo_empty,
  output logic              input_fifo_full,
  output logic              input_fifo_afull,
  output logic [ADDR_W:0]   input_fifo_count
`ifdef INPUT_FIFO_ERR_EN
  ,
  input  logic              err_clr,
  output logic              input_fifo_ovf,
  output logic              input_fifo_udf
`endif
);

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] AFULL_C = (ADDR_W+1)'(AFULL_THRESH);

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              push_acc, pop_acc;
  logic              empty, full;
  logic [DATA_W-1:0] head_dat;

  // Pointer difference mod 2^(ADDR_W+1) is the occupancy, thanks to the wrap bit.
  assign input_fifo_count = wr_ptr_q - rd_ptr_q;
  assign empty            = (wr_ptr_q == rd_ptr_q);
  assign full             = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                            (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

  assign input_fifo_empty = empty;
  assign input_fifo_full  = full;
  assign input_fifo_afull = (input_fifo_count >= AFULL_C);

  // A pop frees the slot a simultaneous push needs when full; no write-through when empty.
  assign pop_acc  = input_de && !empty;
  assign push_acc = input_en && (!full || pop_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (push_acc && !rst),
    .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
    .wr_data_i (input_d),
    .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
    .rd_data_o (head_dat)
  );

  assign input_q = empty ? '0 : head_dat;

`ifdef INPUT_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // A new error event wins over a same-cycle clear.
  always_comb begin
    ovf_d = err_clr ? 1'b0 : ovf_q;
    udf_d = err_clr ? 1'b0 : udf_q;
    if (input_en && !push_acc) ovf_d = 1'b1;
    if (input_de && empty)     udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign input_fifo_ovf = ovf_q;
  assign input_fifo_udf = udf_q;
`endif

endmodule

// File: tb/tb_input_fifo.sv
// Directed + randomized bench for input_fifo against a queue-based occupancy model.
module tb_input_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AFT   = 14;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          input_en;
  logic [DW-1:0] input_d;
  logic          input_de;
  logic          err_clr;
  logic [DW-1:0] input_q;
  logic          input_fifo_empty;
  logic          input_fifo_full;
  logic          input_fifo_afull;
  logic [CW-1:0] input_fifo_count;
  logic          input_fifo_ovf;
  logic          input_fifo_udf;

  int vectors    = 0;
  int miscompares = 0;

  logic [DW-1:0] mq[$];
  logic          movf = 1'b0;
  logic          mudf = 1'b0;
  int            max_cnt;

  input_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_THRESH(AFT)) dut (
    .clk              (clk),
    .rst              (rst),
    .input_en         (input_en),
    .input_d          (input_d),
    .input_de         (input_de),
    .input_q          (input_q),
    .input_fifo_empty (input_fifo_empty),
    .input_fifo_full  (input_fifo_full),
    .input_fifo_afull (input_fifo_afull),
    .input_fifo_count (input_fifo_count)
`ifdef INPUT_FIFO_ERR_EN
    ,
    .err_clr          (err_clr),
    .input_fifo_ovf   (input_fifo_ovf),
    .input_fifo_udf   (input_fifo_udf)
`endif
  );

`ifndef INPUT_FIFO_ERR_EN
  assign input_fifo_ovf = 1'b0;
  assign input_fifo_udf = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string ph);
    int n;
    n = mq.size();
    chk({ph, " count"}, 32'(input_fifo_count), 32'(n));
    chk({ph, " empty"}, 32'(input_fifo_empty), 32'(n == 0));
    chk({ph, " full"},  32'(input_fifo_full),  32'(n == DEPTH));
    chk({ph, " afull"}, 32'(input_fifo_afull), 32'(n >= AFT));
    chk({ph, " q"},     32'(input_q),          32'((n == 0) ? 16'h0 : mq[0]));
`ifdef INPUT_FIFO_ERR_EN
    chk({ph, " ovf"},   32'(input_fifo_ovf),   32'(movf));
    chk({ph, " udf"},   32'(input_fifo_udf),   32'(mudf));
`endif
  endtask

  // One clock: drive, confirm outputs ignore the new inputs, clock, update model, recheck.
  task automatic cycle(input logic en, input logic [DW-1:0] d, input logic de, input logic clr);
    logic emp, pop, push;
    input_en = en;
    input_d  = d;
    input_de = de;
    err_clr  = clr;
    #1 check_outputs("pre");
    @(posedge clk);
    if (rst) begin
      mq.delete();
      movf = 1'b0;
      mudf = 1'b0;
    end else begin
      emp  = (mq.size() == 0);
      pop  = de && !emp;
      push = en && ((mq.size() < DEPTH) || pop);
`ifdef INPUT_FIFO_ERR_EN
      if (clr)        begin movf = 1'b0; mudf = 1'b0; end
      if (en && !push) movf = 1'b1;
      if (de && emp)   mudf = 1'b1;
`endif
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(d);
    end
    #1 check_outputs("post");
    if (int'(input_fifo_count) > max_cnt) max_cnt = int'(input_fifo_count);
  endtask

  initial begin
    rst = 1'b1; input_en = 1'b0; input_d = '0; input_de = 1'b0; err_clr = 1'b0;
    max_cnt = 0;
    @(posedge clk); #1;
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 16'h1234, 1'b1, 1'b0);
    rst = 1'b0;
    chk("reset q", 32'(input_q), 32'h0);

    // Fill 0x0001..0x0010, then drain in order.
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, DW'(i), 1'b0, 1'b0);
      if (i == AFT - 1) chk("afull before 14", 32'(input_fifo_afull), 32'h0);
      if (i == AFT)     chk("afull at 14",     32'(input_fifo_afull), 32'h1);
    end
    chk("fill full", 32'(input_fifo_full), 32'h1);
    chk("fill head", 32'(input_q), 32'h0001);
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain order", 32'(input_q), 32'(i));
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    chk("drained q", 32'(input_q), 32'h0);

    // Full boundary: push+pop keeps it full, lone push is dropped.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
    chk("full push+pop count", 32'(input_fifo_count), 32'(DEPTH));
    cycle(1'b1, 16'hDEAD, 1'b0, 1'b0);
`ifdef INPUT_FIFO_ERR_EN
    chk("ovf set", 32'(input_fifo_ovf), 32'h1);
`endif
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("beef last", 32'(input_q), 32'hBEEF);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Empty boundary: pop rejected, push accepted, no write-through.
    cycle(1'b1, 16'h00AA, 1'b1, 1'b0);
    chk("empty push+pop q", 32'(input_q), 32'h00AA);
`ifdef INPUT_FIFO_ERR_EN
    chk("udf set", 32'(input_fifo_udf), 32'h1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("udf cleared", 32'(input_fifo_udf), 32'h0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("udf clr+event", 32'(input_fifo_udf), 32'h1);
`else
    cycle(1'b0, '0, 1'b1, 1'b0);
`endif

    // Wrap-around with low occupancy.
    max_cnt = 0;
    for (int pushed = 0; pushed < 40; ) begin
      logic en, de;
      en = (mq.size() < 3) && ($urandom_range(0, 3) != 0);
      de = (mq.size() >= 3) || ($urandom_range(0, 1) == 1);
      cycle(en, DW'($urandom), de, 1'b0);
      if (en) pushed++;
    end
    chk("wrap max occupancy", 32'(max_cnt <= 3), 32'h1);
    while (mq.size() != 0) cycle(1'b0, '0, 1'b1, 1'b0);

    // Random traffic including overflow, underflow and clears.
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 99) < 55, DW'($urandom), $urandom_range(0, 99) < 45,
            $urandom_range(0, 15) == 0);
    end

    // Mid-operation reset with a same-cycle push.
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    rst = 1'b1;
    cycle(1'b1, 16'h5555, 1'b1, 1'b0);
    rst = 1'b0;
    chk("rst count", 32'(input_fifo_count), 32'h0);
    chk("rst empty", 32'(input_fifo_empty), 32'h1);
    chk("rst q",     32'(input_q),          32'h0);
    cycle(1'b1, 16'h0F0F, 1'b0, 1'b0);
    chk("post-rst head", 32'(input_q), 32'h0F0F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
